// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the split-transaction bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_M1_OWN       = 2'd1,
        ST_M2_OWN       = 2'd2,
        ST_SPLIT_RETURN = 2'd3
    } arb_state_t;

    typedef enum logic {
        M1 = 1'b0,
        M2 = 1'b1
    } master_id_t;

    localparam int ARB_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/arb_watchdog.sv
// Grant-hold watchdog: counts held cycles and flags the last allowed cycle.
module arb_watchdog #(
    parameter int LIMIT = 64,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Expire on the final permitted cycle so the owner gets exactly LIMIT cycles.
    assign o_expire = i_enable && (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/split_bus_arbiter.sv
// Two-master arbiter that also owns the split target's deferred-read return path.
module split_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m1_req_split,
    input  logic       m2_req_split,
    input  logic       s_ack,
    input  logic       s_split_ack,
    input  logic       split_req,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       split_grant,
    output logic       split_pending,
    output logic       split_owner,
    output logic       timeout,
    output logic [1:0] dbg_state
);

    arb_state_t r_state;
    master_id_t r_last_grant;
    master_id_t r_split_owner;
    logic       r_split_pending;
    logic       r_m1_grant;
    logic       r_m2_grant;
    logic       r_split_grant;
    logic       r_timeout;

    logic w_m1_elig;
    logic w_m2_elig;
    logic w_wd_clear;
    logic w_wd_expire;

    // Every owning state is entered from IDLE, so holding the count at zero there clears it on entry.
    assign w_wd_clear = (r_state == ST_IDLE);

    arb_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_wd_clear),
        .i_enable(!w_wd_clear),
        .o_expire(w_wd_expire)
    );

    assign w_m1_elig = m1_req && !(r_split_pending && ((r_split_owner == M1) || m1_req_split));
    assign w_m2_elig = m2_req && !(r_split_pending && ((r_split_owner == M2) || m2_req_split));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_last_grant    <= M2;
            r_split_owner   <= M1;
            r_split_pending <= 1'b0;
            r_m1_grant      <= 1'b0;
            r_m2_grant      <= 1'b0;
            r_split_grant   <= 1'b0;
            r_timeout       <= 1'b0;
        end else begin
            r_split_grant <= 1'b0;
            r_timeout     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_split_pending && split_req) begin
                        r_state       <= ST_SPLIT_RETURN;
                        r_split_grant <= 1'b1;
                        r_m1_grant    <= (r_split_owner == M1);
                        r_m2_grant    <= (r_split_owner == M2);
                    end else if (w_m1_elig && (!w_m2_elig || r_last_grant == M2)) begin
                        r_state      <= ST_M1_OWN;
                        r_m1_grant   <= 1'b1;
                        r_last_grant <= M1;
                    end else if (w_m2_elig) begin
                        r_state      <= ST_M2_OWN;
                        r_m2_grant   <= 1'b1;
                        r_last_grant <= M2;
                    end
                end
                ST_M1_OWN, ST_M2_OWN: begin
                    // A deferred read outranks a plain completion arriving in the same cycle.
                    if (s_split_ack || s_ack || w_wd_expire) begin
                        r_state    <= ST_IDLE;
                        r_m1_grant <= 1'b0;
                        r_m2_grant <= 1'b0;
                    end
                    if (s_split_ack) begin
                        r_split_pending <= 1'b1;
                        r_split_owner   <= (r_state == ST_M1_OWN) ? M1 : M2;
                    end else if (!s_ack && w_wd_expire) begin
                        r_timeout <= 1'b1;
                    end
                end
                ST_SPLIT_RETURN: begin
                    if (s_ack || w_wd_expire) begin
                        r_state         <= ST_IDLE;
                        r_m1_grant      <= 1'b0;
                        r_m2_grant      <= 1'b0;
                        r_split_pending <= 1'b0;
                        r_timeout       <= !s_ack;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m1_grant      = r_m1_grant;
    assign m2_grant      = r_m2_grant;
    assign split_grant   = r_split_grant;
    assign split_pending = r_split_pending;
    assign split_owner   = r_split_owner;
    assign timeout       = r_timeout;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Randomized bench for split_bus_arbiter: a bus-level reference model predicts every cycle's outputs.
module tb_split_bus_arbiter;

  localparam int T        = 4;
  localparam int W        = 6;
  localparam int N_CYCLES = 4000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m1_req, m2_req, m1_req_split, m2_req_split;
  logic       s_ack, s_split_ack, split_req;
  logic       m1_grant, m2_grant, split_grant, split_pending, split_owner, timeout;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  split_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m1_req       (m1_req),
    .m2_req       (m2_req),
    .m1_req_split (m1_req_split),
    .m2_req_split (m2_req_split),
    .s_ack        (s_ack),
    .s_split_ack  (s_split_ack),
    .split_req    (split_req),
    .m1_grant     (m1_grant),
    .m2_grant     (m2_grant),
    .split_grant  (split_grant),
    .split_pending(split_pending),
    .split_owner  (split_owner),
    .timeout      (timeout),
    .dbg_state    (dbg_state)
  );

  // Expected vector layout: {m1_grant, m2_grant, split_grant, split_pending, owner_is_m2 (masked), timeout}
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who holds the bus, for how long, and what deferred read is outstanding.
  int m_holder;     // 0 = nobody, 1 = M1, 2 = M2
  int m_held;       // cycles the current holder has already had the bus
  int m_owner;      // master owning the deferred read
  int m_last;       // master most recently given a fresh (non-return) grant
  bit m_returning;
  bit m_pending;
  bit m_sg;
  bit m_to;

  // Stimulus bookkeeping
  bit w1, w2, sp1, sp2, sreq, cur_split;
  int n_resets = 0;

  function automatic logic [W-1:0] model_outputs();
    return {m_holder == 1, m_holder == 2, m_sg, m_pending, m_pending && (m_owner == 2), m_to};
  endfunction

  task automatic model_reset();
    m_holder = 0; m_held = 0; m_owner = 1; m_last = 2;
    m_returning = 0; m_pending = 0; m_sg = 0; m_to = 0;
  endtask

  task automatic model_step(input bit r1, input bit s1, input bit r2, input bit s2,
                            input bit ack, input bit sack, input bit sr);
    bit e1, e2;
    int pick;
    m_sg = 0;
    m_to = 0;
    if (m_holder == 0) begin
      e1 = r1 && !(m_pending && (m_owner == 1 || s1));
      e2 = r2 && !(m_pending && (m_owner == 2 || s2));
      if (m_pending && sr) begin
        m_holder = m_owner; m_returning = 1; m_held = 0; m_sg = 1;
      end else begin
        pick = 0;
        if (e1 && e2) pick = (m_last == 1) ? 2 : 1;
        else if (e1)  pick = 1;
        else if (e2)  pick = 2;
        if (pick != 0) begin
          m_holder = pick; m_returning = 0; m_held = 0; m_last = pick;
        end
      end
    end else if (!m_returning) begin
      if (sack) begin
        m_pending = 1; m_owner = m_holder; m_holder = 0;
      end else if (ack) begin
        m_holder = 0;
      end else if (m_held == T - 1) begin
        m_holder = 0; m_to = 1;
      end else begin
        m_held++;
      end
    end else begin
      if (ack) begin
        m_pending = 0; m_holder = 0; m_returning = 0;
      end else if (m_held == T - 1) begin
        m_pending = 0; m_holder = 0; m_returning = 0; m_to = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [W-1:0] got;
    got = {m1_grant, m2_grant, split_grant, split_pending, split_owner, timeout};
    n_checks++;
    if (got !== '0) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%b required=000000 (m1 m2 sg pend owner to)", name, $time, got);
    end
  endtask

  // Monitor: one expected vector per clock edge, compared shortly after the edge.
  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {m1_grant, m2_grant, split_grant, split_pending,
                 split_pending & split_owner, timeout};
        n_checks++;
        if (got_v !== exp_v) begin
          n_errors++;
          $display("FAIL cycle_outputs t=%0t got=%b required=%b (m1 m2 sg pend owner_m2 to) state=%0d",
                   $time, got_v, exp_v, dbg_state);
        end
      end
    end
  end

  // Driver: random but protocol-legal stimulus; legality is judged from the model, never the DUT.
  initial begin
    int prev_holder;
    int r;
    m1_req = 0; m2_req = 0; m1_req_split = 0; m2_req_split = 0;
    s_ack = 0; s_split_ack = 0; split_req = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_values");
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Both masters request on the first cycle out of reset: M1 must win the tie.
    w1 = 1; w2 = 1; sp1 = 1'($urandom_range(0, 1)); sp2 = 1'($urandom_range(0, 1));
    sreq = 0; cur_split = 0;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);

      if (m_returning && n_resets < 3 && $urandom_range(0, 3) == 0) begin
        rst_n = 1'b0;
        m1_req = 0; m2_req = 0; m1_req_split = 0; m2_req_split = 0;
        s_ack = 0; s_split_ack = 0; split_req = 0;
        #1 check_all_zero("async_reset_in_split_return");
        model_reset();
        exp_q.push_back(model_outputs());
        w1 = 1; w2 = 1; sp1 = 1'($urandom_range(0, 1)); sp2 = 1'($urandom_range(0, 1));
        sreq = 0;
        n_resets++;
        @(negedge clk);
        rst_n = 1'b1;
      end

      if (!w1 && m_holder != 1 && $urandom_range(0, 3) == 0) begin
        w1 = 1; sp1 = 1'($urandom_range(0, 1));
      end
      if (!w2 && m_holder != 2 && $urandom_range(0, 3) == 0) begin
        w2 = 1; sp2 = 1'($urandom_range(0, 1));
      end
      if (m_pending && !sreq && $urandom_range(0, 3) == 0) sreq = 1;

      m1_req = w1; m1_req_split = w1 & sp1;
      m2_req = w2; m2_req_split = w2 & sp2;
      split_req = sreq;
      s_ack = 0; s_split_ack = 0;
      if (m_holder != 0) begin
        r = $urandom_range(0, 9);
        if (m_returning) begin
          // The split target's pipeline returns data two cycles after split_grant.
          if (m_held >= 2 && r < 5) s_ack = 1;
        end else begin
          if (r < 3) s_ack = 1;
          else if (r == 3 && cur_split && !m_pending) s_split_ack = 1;
          else if (r == 4 && cur_split && !m_pending) begin
            s_ack = 1; s_split_ack = 1;
          end
        end
      end

      prev_holder = m_holder;
      model_step(m1_req, m1_req_split, m2_req, m2_req_split, s_ack, s_split_ack, split_req);
      exp_q.push_back(model_outputs());

      if (prev_holder == 0 && m_holder != 0 && !m_returning) begin
        if (m_holder == 1) begin
          w1 = 0; cur_split = sp1;
        end else begin
          w2 = 0; cur_split = sp2;
        end
      end
      if (m_sg || !m_pending) sreq = 0;
    end

    @(negedge clk);
    m1_req = 0; m2_req = 0; s_ack = 0; s_split_ack = 0; split_req = 0;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got=%0d leftover entries required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
